emmc_dev_cmd_responder: RTL and testbench
=========================================

// Module: emmc_dev_cmd_responder
// PURPOSE
//  Device-side (card) end of the eMMC CMD line: deserialises 48-bit host command tokens, checks CRC7,
//  runs the card identification state machine (idle/ready/ident/stby/tran), and serialises R1/R2/R3
//  responses. Used as the card model opposite the host init/transfer controller, in sim and on FPGA loopback.
//  Commands outside the identification set are passed to the data side via cmd_valid.
// PARAMETERS
//  NCR      2                       bit-times from command end bit to response start bit (1..63)
//  OCR      32'hC0FF_8080           R3 payload; bit31 (power-up done) is always set in the response
//  CID      128'h15010044_4A323541_0001E240_12345601   R2 payload for CMD2; [7:1] recomputed, [0]=1
//  CSD      128'hD0270132_0F5903FF_F6DBFFEF_8E400001   R2 payload for CMD9; [7:1] recomputed, [0]=1
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  bit_en       in   1    one-cycle strobe per CMD bit-time; line is sampled/driven only when high
//  cmd_i        in   1    CMD line sampled value
//  cmd_o        out  1    CMD line drive value
//  cmd_oe       out  1    CMD line output enable (1 = device drives)
//  cmd_valid    out  1    1-cycle pulse: accepted non-identification command in TRAN state
//  cmd_index    out  6    index of last accepted command (valid with cmd_valid)
//  cmd_arg      out  32   argument of last accepted command
//  dev_state    out  4    current state: 0 IDLE,1 READY,2 IDENT,3 STBY,4 TRAN
//  rca          out  16   relative card address
// BEHAVIOUR
//  - Reset: cmd_o=1, cmd_oe=0, cmd_valid=0, cmd_index=0, cmd_arg=0, dev_state=IDLE, rca=0, err bits=0.
//  - All sequencing advances only on clk cycles with bit_en=1; cmd_valid pulses on the clk after the end bit.
//  - FSM: RX_HUNT (wait cmd_i=0) -> RX_BITS (47 more bits) -> CHECK -> WAIT_NCR -> TX_BITS -> RX_HUNT.
//  - Token: start 0, dir 1, index[5:0], arg[31:0], CRC7, end 1; dir=0 or end=0 -> frame error, drop, RX_HUNT.
//  - CRC7 poly x^7+x^3+1 over first 40 bits; mismatch -> set COM_CRC_ERROR (status[23]), no response.
//  - Command table (other index/state combos -> ILLEGAL_COMMAND status[22], no response):
//    CMD0 any state       -> IDLE, rca kept, no response
//    CMD1 IDLE/READY      -> READY, R3 = 0,0,111111,OCR|bit31,1111111,1
//    CMD2 READY           -> IDENT, R2 CID
//    CMD3 IDENT           -> STBY, rca<=arg[31:16], R1
//    CMD9 STBY, arg[31:16]==rca -> R2 CSD (RCA mismatch: no response, no error)
//    CMD7 STBY, match     -> TRAN, R1;  TRAN, mismatch -> STBY, no response
//    CMD13 STBY/TRAN, match -> R1, no state change
//    any other index in TRAN -> cmd_valid pulse, R1
//  - R1: 0,0,index,status[31:0],CRC7,1. status: [23],[22] error flags, [12:9]=state when command was
//    received, [8]=1; all other bits 0. Error flags clear after being sent in any R1.
//  - R2: 0,0,111111, payload[127:8], CRC7 over payload[127:8], 1 (136 bits total).
//  - Response start bit is driven exactly NCR bit-times after the command end bit; cmd_oe rises with the
//    start bit, falls on the bit-time after the end bit; cmd_o=1 whenever cmd_oe=0.
//  - Bits arriving while cmd_oe=1 are ignored; RX_HUNT resumes on the first bit-time after cmd_oe falls.
//  - rst mid-reception or mid-response: cmd_oe=0 on the next clk, all state to reset values.
//  - bit_en held low: FSM, counters and outputs frozen.
// CONFIGURATION
//  EMMC_DEV_CRC_CHECK_EN defined: CRC7 of received commands checked as above.
//  Not defined: received CRC field ignored, COM_CRC_ERROR never set; response CRC7 always generated.
// TESTING
//  - CMD0 frame 0x40_00000000_95 in TRAN -> no cmd_oe assertion, dev_state=0.
//  - CMD1 valid CRC, OCR default -> after NCR=2 bit-times, 48-bit R3 = 0x3F_C0FF8080_FF.
//  - CMD1,CMD2,CMD3 arg 0x0001_0000,CMD7 arg 0x0001_0000 -> dev_state 1,2,3,4, rca=0x0001; CMD3 R1 status=0x0000_0500.
//  - CMD13 arg 0x0001_0000 in TRAN -> R1 index 13 status 0x0000_0900; arg 0x0002_0000 -> no response.
//  - CMD13 with one flipped CRC bit -> no response; next valid CMD13 R1 status 0x0080_0900, following 0x0000_0900.
//  - rst pulse at response bit 20 -> cmd_oe=0 next clk, dev_state=0, rca=0; CMD17 arg 0x10 in TRAN -> cmd_valid with index 17.

Source files
------------

// File: rtl/emmc_dev_cmd_responder.sv
// Card-side eMMC CMD line: receives 48-bit command tokens, runs the identification state machine and
// serialises R1/R2/R3 responses. Define EMMC_DEV_CRC_CHECK_EN to check the CRC7 of received commands.
module emmc_dev_cmd_responder #(
    parameter int             NCR = 2,
    parameter logic [31:0]    OCR = 32'hC0FF_8080,
    parameter logic [127:0]   CID = 128'h15010044_4A323541_0001E240_12345601,
    parameter logic [127:0]   CSD = 128'hD0270132_0F5903FF_F6DBFFEF_8E400001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [3:0]  dev_state,
    output logic [15:0] rca
);
    typedef enum logic [2:0] {RX_HUNT, RX_BITS, CHECK, WAIT_NCR, TX_BITS} phase_t;
    typedef enum logic [2:0] {RSP_NONE, RSP_R1, RSP_R2_CID, RSP_R2_CSD, RSP_R3} resp_t;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_READY = 4'd1;
    localparam logic [3:0] ST_IDENT = 4'd2;
    localparam logic [3:0] ST_STBY  = 4'd3;
    localparam logic [3:0] ST_TRAN  = 4'd4;

    phase_t         phase;
    logic [47:0]    rx_sr;
    logic [5:0]     rx_cnt;
    logic [5:0]     ncr_cnt;
    logic [135:0]   tx_sr;
    logic [7:0]     tx_cnt;
    logic [7:0]     tx_len;
    logic           crc_err;
    logic           ill_err;

    // CRC7 (x^7+x^3+1) over the top n bits of a left-aligned 120-bit field
    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 0; i < 120; i++) begin
            if (i < n) begin
                fb = d[119-i] ^ c[6];
                c  = {c[5:0], 1'b0};
                if (fb) c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    logic [5:0]  rx_idx;
    logic [31:0] rx_arg;
    logic        frame_ok;
    logic        crc_ok;
    logic        rca_hit;
    assign rx_idx   = rx_sr[45:40];
    assign rx_arg   = rx_sr[39:8];
    assign frame_ok = !rx_sr[47] && rx_sr[46] && rx_sr[0];
    assign rca_hit  = (rx_arg[31:16] == rca);
`ifdef EMMC_DEV_CRC_CHECK_EN
    assign crc_ok = (crc7({rx_sr[47:8], 80'h0}, 40) == rx_sr[7:1]);
`else
    logic crc_field_unused;
    assign crc_field_unused = ^rx_sr[7:1];
    assign crc_ok = 1'b1;
`endif

    logic [3:0] dec_state;
    resp_t      resp;
    logic       set_ill;
    logic       do_valid;
    logic       load_rca;

    always_comb begin
        dec_state = dev_state;
        resp      = RSP_NONE;
        set_ill   = 1'b0;
        do_valid  = 1'b0;
        load_rca  = 1'b0;
        case (rx_idx)
            6'd0: dec_state = ST_IDLE;
            6'd1: if (dev_state == ST_IDLE || dev_state == ST_READY) begin
                      dec_state = ST_READY;
                      resp      = RSP_R3;
                  end else set_ill = 1'b1;
            6'd2: if (dev_state == ST_READY) begin
                      dec_state = ST_IDENT;
                      resp      = RSP_R2_CID;
                  end else set_ill = 1'b1;
            6'd3: if (dev_state == ST_IDENT) begin
                      dec_state = ST_STBY;
                      load_rca  = 1'b1;
                      resp      = RSP_R1;
                  end else set_ill = 1'b1;
            // An address mismatch deselects silently rather than flagging an error
            6'd7: if (dev_state == ST_STBY) begin
                      if (rca_hit) begin
                          dec_state = ST_TRAN;
                          resp      = RSP_R1;
                      end
                  end else if (dev_state == ST_TRAN) begin
                      if (!rca_hit) dec_state = ST_STBY;
                      else          set_ill   = 1'b1;
                  end else set_ill = 1'b1;
            6'd9: if (dev_state == ST_STBY) begin
                      if (rca_hit) resp = RSP_R2_CSD;
                  end else set_ill = 1'b1;
            6'd13: if (dev_state == ST_STBY || dev_state == ST_TRAN) begin
                      if (rca_hit) resp = RSP_R1;
                  end else set_ill = 1'b1;
            default: if (dev_state == ST_TRAN) begin
                      do_valid = 1'b1;
                      resp     = RSP_R1;
                  end else set_ill = 1'b1;
        endcase
    end

    logic [31:0]  status;
    logic [39:0]  r1_head;
    logic [135:0] resp_sr;
    logic [7:0]   resp_len;

    always_comb begin
        status       = '0;
        status[23]   = crc_err;
        status[22]   = ill_err;
        status[12:9] = dev_state;
        status[8]    = 1'b1;
        r1_head      = {2'b00, rx_idx, status};
        resp_len     = 8'd48;
        case (resp)
            RSP_R1:     resp_sr = {r1_head, crc7({r1_head, 80'h0}, 40), 1'b1, 88'h0};
            RSP_R3:     resp_sr = {8'h3F, OCR | 32'h8000_0000, 8'hFF, 88'h0};
            RSP_R2_CID: begin
                resp_sr  = {8'h3F, CID[127:8], crc7(CID[127:8], 120), 1'b1};
                resp_len = 8'd136;
            end
            RSP_R2_CSD: begin
                resp_sr  = {8'h3F, CSD[127:8], crc7(CSD[127:8], 120), 1'b1};
                resp_len = 8'd136;
            end
            default:    resp_sr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= RX_HUNT;
            rx_sr     <= '0;
            rx_cnt    <= '0;
            ncr_cnt   <= '0;
            tx_sr     <= '0;
            tx_cnt    <= '0;
            tx_len    <= '0;
            crc_err   <= 1'b0;
            ill_err   <= 1'b0;
            cmd_o     <= 1'b1;
            cmd_oe    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            dev_state <= ST_IDLE;
            rca       <= '0;
        end else begin
            cmd_valid <= 1'b0;
            case (phase)
                RX_HUNT: if (bit_en && !cmd_i) begin
                    rx_sr  <= '0;
                    rx_cnt <= 6'd1;
                    phase  <= RX_BITS;
                end
                RX_BITS: if (bit_en) begin
                    rx_sr   <= {rx_sr[46:0], cmd_i};
                    rx_cnt  <= rx_cnt + 6'd1;
                    ncr_cnt <= '0;
                    if (rx_cnt == 6'd47) phase <= CHECK;
                end
                CHECK: begin
                    phase <= RX_HUNT;
                    if (frame_ok) begin
                        if (!crc_ok) crc_err <= 1'b1;
                        else begin
                            cmd_index <= rx_idx;
                            cmd_arg   <= rx_arg;
                            dev_state <= dec_state;
                            cmd_valid <= do_valid;
                            if (load_rca) rca <= rx_arg[31:16];
                            if (set_ill) ill_err <= 1'b1;
                            if (resp != RSP_NONE) begin
                                tx_len <= resp_len;
                                if (resp == RSP_R1) begin
                                    crc_err <= 1'b0;
                                    ill_err <= 1'b0;
                                end
                                // This clk may already be the NCR-th bit-time after the end bit
                                if (bit_en && NCR == 1) begin
                                    cmd_oe <= 1'b1;
                                    cmd_o  <= resp_sr[135];
                                    tx_sr  <= {resp_sr[134:0], 1'b0};
                                    tx_cnt <= 8'd1;
                                    phase  <= TX_BITS;
                                end else begin
                                    tx_sr   <= resp_sr;
                                    ncr_cnt <= bit_en ? 6'd1 : 6'd0;
                                    phase   <= WAIT_NCR;
                                end
                            end
                        end
                    end
                end
                WAIT_NCR: if (bit_en) begin
                    if (ncr_cnt == 6'(NCR - 1)) begin
                        cmd_oe <= 1'b1;
                        cmd_o  <= tx_sr[135];
                        tx_sr  <= {tx_sr[134:0], 1'b0};
                        tx_cnt <= 8'd1;
                        phase  <= TX_BITS;
                    end else ncr_cnt <= ncr_cnt + 6'd1;
                end
                TX_BITS: if (bit_en) begin
                    if (tx_cnt == tx_len) begin
                        cmd_oe <= 1'b0;
                        cmd_o  <= 1'b1;
                        phase  <= RX_HUNT;
                    end else begin
                        cmd_o  <= tx_sr[135];
                        tx_sr  <= {tx_sr[134:0], 1'b0};
                        tx_cnt <= tx_cnt + 8'd1;
                    end
                end
                default: phase <= RX_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_emmc_dev_cmd_responder.sv
// Randomised bench for emmc_dev_cmd_responder against a command-level card model.
module tb_emmc_dev_cmd_responder;
    localparam int          NCR = 2;
    localparam logic [31:0] OCR = 32'hC0FF_8080;
    localparam logic [127:0] CID = 128'h15010044_4A323541_0001E240_12345601;
    localparam logic [127:0] CSD = 128'hD0270132_0F5903FF_F6DBFFEF_8E400001;
`ifdef EMMC_DEV_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, bit_en, cmd_i;
    logic cmd_o, cmd_oe, cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [3:0]  dev_state;
    logic [15:0] rca;

    emmc_dev_cmd_responder #(.NCR(NCR), .OCR(OCR), .CID(CID), .CSD(CSD)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe),
        .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .dev_state(dev_state), .rca(rca)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          vld_cnt = 0;
    logic [5:0]  vld_idx = '0;
    logic [31:0] vld_arg = '0;
    always @(posedge clk) if (cmd_valid) begin
        vld_cnt <= vld_cnt + 1;
        vld_idx <= cmd_index;
        vld_arg <= cmd_arg;
    end

    // card model
    int          m_state;
    logic [15:0] m_rca;
    bit          m_crc, m_ill;

    function automatic logic [6:0] crc_ref(input logic [119:0] d, input int n);
        logic [7:0] rem;
        bit q[$];
        for (int i = 0; i < n; i++) q.push_back(d[119-i]);
        for (int i = 0; i < 7; i++) q.push_back(1'b0);
        rem = '0;
        foreach (q[i]) begin
            rem = {rem[6:0], q[i]};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    task automatic model_reset();
        m_state = 0; m_rca = '0; m_crc = 0; m_ill = 0;
    endtask

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_bad,
                             input bit frame_bad, output int len, output logic [135:0] bits, output bit vld);
        int st;
        bit hit, r1;
        logic [31:0] status;
        logic [39:0] h;
        st = m_state; len = 0; bits = '0; vld = 0; r1 = 0;
        hit = (arg[31:16] == m_rca);
        if (frame_bad) return;
        if (crc_bad && CRC_EN) begin m_crc = 1; return; end
        case (idx)
            0: m_state = 0;
            1: if (st <= 1) begin m_state = 1; len = 48; bits = {8'h3F, OCR | 32'h8000_0000, 8'hFF, 88'h0}; end
               else m_ill = 1;
            2: if (st == 1) begin m_state = 2; len = 136; bits = {8'h3F, CID[127:8], crc_ref(CID[127:8], 120), 1'b1}; end
               else m_ill = 1;
            3: if (st == 2) begin m_state = 3; m_rca = arg[31:16]; r1 = 1; end else m_ill = 1;
            7: if (st == 3) begin if (hit) begin m_state = 4; r1 = 1; end end
               else if (st == 4) begin if (!hit) m_state = 3; else m_ill = 1; end
               else m_ill = 1;
            9: if (st == 3) begin if (hit) begin len = 136; bits = {8'h3F, CSD[127:8], crc_ref(CSD[127:8], 120), 1'b1}; end end
               else m_ill = 1;
            13: if (st == 3 || st == 4) r1 = hit; else m_ill = 1;
            default: if (st == 4) begin vld = 1; r1 = 1; end else m_ill = 1;
        endcase
        if (r1) begin
            status = 32'(m_crc) << 23 | 32'(m_ill) << 22 | 32'(st) << 9 | 32'h100;
            h = {2'b00, idx, status};
            len = 48;
            bits = {h, crc_ref({h, 80'h0}, 40), 1'b1, 88'h0};
            m_crc = 0; m_ill = 0;
        end
    endtask

    // bit-time driver: entered and left just after a negedge
    logic s_oe, s_o;
    task automatic bit_time(input logic b);
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
            bit_en = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bit_en = 1'b1; cmd_i = b;
        @(negedge clk);
        bit_en = 1'b0; cmd_i = 1'b1;
        s_oe = cmd_oe; s_o = cmd_o;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_en = 1'b0; cmd_i = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [135:0] g_bits;
    int           g_len;

    // send one command, capture the response and check it against the model
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit flip,
                            input bit frame_bad, input int rst_at);
        logic [47:0]  tok;
        logic [6:0]   crc;
        logic [135:0] e_bits;
        int           e_len, start_off, v0;
        bit           e_vld, idle_bad;
        crc = crc_ref({2'b01, idx, arg, 80'h0}, 40);
        if (flip) crc = crc ^ (7'h01 << $urandom_range(0, 6));
        tok = {1'b0, !frame_bad, idx, arg, crc, 1'b1};
        v0 = vld_cnt;
        model_cmd(idx, arg, flip, frame_bad, e_len, e_bits, e_vld);
        for (int i = 47; i >= 0; i--) bit_time(tok[i]);
        g_len = 0; g_bits = '0; start_off = -1; idle_bad = 0;
        for (int j = 1; j <= NCR + 145; j++) begin
            bit_time(1'b1);
            if (s_oe) begin
                if (start_off < 0) start_off = j;
                if (g_len < 136) g_bits[135-g_len] = s_o;
                g_len++;
                if (g_len == rst_at) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    chk("rst_oe", cmd_oe, 0);
                    chk("rst_state", dev_state, 0);
                    chk("rst_rca", rca, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    model_reset();
                    return;
                end
            end else begin
                if (s_o !== 1'b1) idle_bad = 1;
                if (start_off >= 0 || j > NCR + 4) break;
            end
        end
        chk($sformatf("len_cmd%0d", idx), g_len, e_len);
        if (e_len > 0) begin
            chk($sformatf("bits_cmd%0d", idx), g_bits, e_bits);
            chk("ncr", start_off, NCR);
        end
        chk("idle_high", idle_bad, 0);
        chk("dev_state", dev_state, m_state);
        chk("rca", rca, m_rca);
        chk("vld_pulses", vld_cnt - v0, e_vld);
        if (e_vld) begin
            chk("vld_index", vld_idx, idx);
            chk("vld_arg", vld_arg, arg);
        end
    endtask

    task automatic to_tran();
        send_cmd(6'd1, 32'h0, 0, 0, -1);
        send_cmd(6'd2, 32'h0, 0, 0, -1);
        send_cmd(6'd3, 32'h0001_0000, 0, 0, -1);
        send_cmd(6'd7, 32'h0001_0000, 0, 0, -1);
    endtask

    initial begin
        logic [5:0] pick [10];
        logic [5:0] idx;
        logic [31:0] arg;
        pick = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd9, 6'd13, 6'd17, 6'd24, 6'd13};
        rst = 1'b1; bit_en = 1'b0; cmd_i = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_oe", cmd_oe, 0);
        chk("reset_o", cmd_o, 1);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_index", cmd_index, 0);
        chk("reset_arg", cmd_arg, 0);
        chk("reset_state", dev_state, 0);
        chk("reset_rca", rca, 0);

        send_cmd(6'd1, 32'h0, 0, 0, -1);
        chk("r3_literal", g_bits[135:88], 48'h3F_C0FF8080_FF);
        send_cmd(6'd2, 32'h0, 0, 0, -1);
        send_cmd(6'd3, 32'h0001_0000, 0, 0, -1);
        chk("cmd3_status", g_bits[127:96], 32'h0000_0500);
        send_cmd(6'd7, 32'h0001_0000, 0, 0, -1);
        chk("tran_state", dev_state, 4);
        chk("tran_rca", rca, 16'h0001);
        send_cmd(6'd13, 32'h0001_0000, 0, 0, -1);
        chk("cmd13_status", g_bits[127:96], 32'h0000_0900);
        send_cmd(6'd13, 32'h0002_0000, 0, 0, -1);
        send_cmd(6'd13, 32'h0001_0000, 1, 0, -1);
        send_cmd(6'd13, 32'h0001_0000, 0, 0, -1);
        chk("crc_err_status", g_bits[127:96], CRC_EN ? 32'h0080_0900 : 32'h0000_0900);
        send_cmd(6'd13, 32'h0001_0000, 0, 0, -1);
        chk("crc_err_cleared", g_bits[127:96], 32'h0000_0900);
        send_cmd(6'd0, 32'h0, 0, 0, -1);
        chk("cmd0_state", dev_state, 0);
        send_cmd(6'd13, 32'h0001_0000, 0, 1, -1);

        to_tran();
        send_cmd(6'd13, 32'h0001_0000, 0, 0, 20);
        to_tran();
        send_cmd(6'd17, 32'h0000_0010, 0, 0, -1);
        chk("cmd17_index", vld_idx, 17);

        for (int n = 0; n < 80; n++) begin
            idx = pick[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            if ($urandom_range(0, 1) == 1) arg[31:16] = m_rca;
            send_cmd(idx, arg, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
